// File: rtl/dct_transpose_buf.sv
// dct_transpose_buf: ping-pong N x N block buffer, emits each block transposed or straight.
// Define DCT_TPB_ROUND_EN for a rounded, shifted and saturated output with a sat pulse.
module dct_transpose_buf #(
    parameter int DATA_WIDTH = 18,
    parameter int OUT_WIDTH  = 18,
    parameter int N          = 8,
    parameter int SHIFT      = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [N*DATA_WIDTH-1:0]   s_data,
    input  logic                      s_mode,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [N*OUT_WIDTH-1:0]    m_data,
    output logic                      m_first,
    output logic                      m_last,
    output logic                      sat
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    logic [DATA_WIDTH-1:0] mem [2][N][N];
    logic [1:0] full;
    logic [1:0] mode;
    logic wr_bank, rd_bank;
    logic [AW-1:0] wr_row, rd_idx;
    logic wr_en, rd_en;
    logic signed [DATA_WIDTH-1:0] x;
    logic [N*OUT_WIDTH-1:0] lanes;

    assign s_ready = !full[wr_bank];
    assign m_valid = full[rd_bank];
    assign wr_en   = s_valid && s_ready;
    assign rd_en   = m_valid && m_ready;
    assign m_first = m_valid && rd_idx == '0;
    assign m_last  = m_valid && rd_idx == LAST;
    assign m_data  = m_valid ? lanes : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < N; c++)
                mem[wr_bank][wr_row][AW'(c)] <= s_data[c*DATA_WIDTH +: DATA_WIDTH];
            if (wr_row == '0)
                mode[wr_bank] <= s_mode;
        end
    end

    // A write can only target an EMPTY bank and a read only a FULL one, so both
    // completions in one edge always touch different banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_idx  <= '0;
        end else begin
            if (wr_en) begin
                wr_row <= wr_row + 1'b1;
                if (wr_row == LAST) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= !wr_bank;
                end
            end
            if (rd_en) begin
                rd_idx <= rd_idx + 1'b1;
                if (rd_idx == LAST) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= !rd_bank;
                end
            end
        end
    end

`ifdef DCT_TPB_ROUND_EN
    localparam int XW = (DATA_WIDTH + 1 > OUT_WIDTH ? DATA_WIDTH + 1 : OUT_WIDTH) + 1;
    localparam logic signed [XW-1:0] RND  = XW'((1 << SHIFT) >> 1);
    localparam logic signed [XW-1:0] MAXV = XW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] MINV = XW'(-(1 << (OUT_WIDTH - 1)));
    logic signed [XW-1:0] y;
    logic any_sat;

    assign sat = rd_en && any_sat;
`else
    assign sat = 1'b0;
`endif

    always_comb begin
        lanes = '0;
        x = '0;
`ifdef DCT_TPB_ROUND_EN
        y = '0;
        any_sat = 1'b0;
`endif
        for (int k = 0; k < N; k++) begin
            x = mode[rd_bank] ? mem[rd_bank][AW'(k)][rd_idx] : mem[rd_bank][rd_idx][AW'(k)];
`ifdef DCT_TPB_ROUND_EN
            y = (XW'(x) + RND) >>> SHIFT;
            any_sat = any_sat | (y > MAXV) | (y < MINV);
            lanes[k*OUT_WIDTH +: OUT_WIDTH] = y > MAXV ? MAXV[OUT_WIDTH-1:0] :
                                              y < MINV ? MINV[OUT_WIDTH-1:0] : y[OUT_WIDTH-1:0];
`else
            lanes[k*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(x);
`endif
        end
    end
endmodule

// File: tb/tb_dct_transpose_buf.sv
// tb_dct_transpose_buf: random and directed streaming against a block-level reference model.
module tb_dct_transpose_buf;
    localparam int N  = 8;
    localparam int DW = 18;
`ifdef DCT_TPB_ROUND_EN
    localparam int OW = 12;
    localparam int SH = 2;
`else
    localparam int OW = 18;
    localparam int SH = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0;
    logic s_ready;
    logic [N*DW-1:0] s_data = '0;
    logic s_mode = 1'b0;
    logic m_valid;
    logic m_ready = 1'b0;
    logic [N*OW-1:0] m_data;
    logic m_first, m_last, sat;

    int checks = 0;
    int errors = 0;
    int rmode = 2;

    logic [N*OW-1:0] q[$];
    bit sq[$];
    int blk[N][N];
    int mrow = 0;
    bit mmode = 1'b0;
    int beat = 0;
    bit hold = 1'b0;
    logic [N*OW-1:0] held;
    int sp[5] = '{5, -6, 131071, -131072, -7};

    dct_transpose_buf #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .N(N), .SHIFT(SH)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_mode(s_mode),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_first(m_first), .m_last(m_last), .sat(sat)
    );

    always #5 clk = !clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int conv(input int v, output bit s);
`ifdef DCT_TPB_ROUND_EN
        int y, hi, lo;
        y  = (v + ((1 << SH) >> 1)) >>> SH;
        hi = (1 << (OW - 1)) - 1;
        lo = -(1 << (OW - 1));
        s  = y > hi || y < lo;
        return y > hi ? hi : y < lo ? lo : y;
`else
        s = 1'b0;
        return v;
`endif
    endfunction

    // Completed block: queue its N output beats in emission order.
    task automatic push_block();
        logic [N*OW-1:0] e;
        bit s, any;
        int t;
        for (int j = 0; j < N; j++) begin
            e = '0;
            any = 1'b0;
            for (int l = 0; l < N; l++) begin
                t = conv(mmode ? blk[l][j] : blk[j][l], s);
                e[l*OW +: OW] = t[OW-1:0];
                any |= s;
            end
            q.push_back(e);
            sq.push_back(any);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid", m_valid, q.size() != 0);
            chk("s_ready", s_ready, (q.size() + N - 1) / N < 2);
            if (q.size() != 0) begin
                chk("m_first", m_first, beat == 0);
                chk("m_last", m_last, beat == N - 1);
                if (hold) chk("hold", m_data, held);
                chk("m_data", m_data, q[0]);
                chk("sat", sat, m_ready && sq[0]);
                hold = !m_ready;
                held = m_data;
                if (m_ready) begin
                    void'(q.pop_front());
                    void'(sq.pop_front());
                    beat = (beat + 1) % N;
                end
            end else begin
                chk("idle_data", m_data, 0);
                chk("idle_flags", {m_first, m_last, sat}, 0);
                hold = 1'b0;
            end
            if (s_valid && s_ready) begin
                if (mrow == 0) mmode = s_mode;
                for (int c = 0; c < N; c++) begin
                    logic [DW-1:0] lv;
                    lv = s_data[c*DW +: DW];
                    blk[mrow][c] = int'($signed(lv));
                end
                mrow++;
                if (mrow == N) begin
                    push_block();
                    mrow = 0;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1 m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(1)) : 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rows(input bit md, input int kind, input int nrows, input bit gaps);
        int v, n;
        bit acc;
        for (int r = 0; r < nrows; r++) begin
            if (gaps && $urandom_range(3) == 0) begin
                s_valid = 1'b0;
                s_data = {N{18'($urandom)}};
                tick();
            end
            s_valid = 1'b1;
            s_mode = r == 0 ? md : 1'($urandom_range(1));
            for (int c = 0; c < N; c++) begin
                v = kind == 0 ? 10 * r + c : kind == 1 ? int'($urandom_range(262143)) - 131072 : sp[(r * N + c) % 5];
                s_data[c*DW +: DW] = v[DW-1:0];
            end
            n = 0;
            forever begin
                acc = s_ready;
                tick();
                if (acc) break;
                if (++n > 500) begin
                    chk("s_timeout", 0, 1);
                    break;
                end
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        s_valid = 1'b0;
        while (q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_flags", {m_first, m_last, sat}, 0);
        chk("rst_m_data", m_data, 0);
        rst_n = 1'b1;
        tick();
        rmode = 0;
        send_rows(1, 0, N, 0);
        send_rows(0, 0, N, 0);
        for (int i = 0; i < 4; i++) send_rows(1'(i % 2), 1, N, 0);
        drain();
        rmode = 2;
        fork
            begin
                for (int i = 0; i < 3; i++) send_rows(1'(i % 2), 1, N, 0);
            end
            begin
                repeat (40) tick();
                chk("bp_s_ready", s_ready, 0);
                chk("bp_m_valid", m_valid, 1);
                rmode = 0;
            end
        join
        drain();
        rmode = 1;
        for (int i = 0; i < 6; i++) send_rows(1'($urandom_range(1)), 1, N, 1);
        send_rows(0, 2, N, 1);
        send_rows(1, 2, N, 0);
        drain();
        rmode = 2;
        send_rows(0, 1, N, 0);
        send_rows(1, 1, 5, 0);
        s_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_s_ready", s_ready, 1);
        chk("mid_rst_m_data", m_data, 0);
        q.delete();
        sq.delete();
        mrow = 0;
        beat = 0;
        hold = 1'b0;
        tick();
        rst_n = 1'b1;
        rmode = 0;
        tick();
        send_rows(1, 0, N, 0);
        drain();
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
